// File: rtl/alk_mdseq.sv
// alk_mdseq: multiply/divide/remainder loop sequencer for the ALK datapath slice
module alk_mdseq #(
  parameter int WIDTH = 32,
  parameter int FAST_BITS = 2,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk_h,
  input  logic             reset_l,
  input  logic [9:0]       alpctl_h,
  input  logic             alu_0xxx_l,
  input  logic             stall_h,
  input  logic             abort_h,
  output logic             busy_h,
  output logic             loop_flag_h,
  output logic             last_step_h,
  output logic             fix_h,
  output logic             shl_op_h,
  output logic             shr_op_h,
  output logic             fast_h,
  output logic             neg_h,
  output logic             mul_l,
  output logic             div_l,
  output logic             divdbl_l,
  output logic             rem_l,
  output logic             done_h,
  output logic [CNT_W-1:0] count_h
);
  typedef enum logic [1:0] {IDLE, LOOP, FIX} state_t;
  localparam logic [CNT_W-1:0] CNT_FAST = CNT_W'(WIDTH / FAST_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_SLOW = CNT_W'(WIDTH - 1);
  state_t state, state_nx;
  logic [CNT_W-1:0] count, count_nx;
  logic [3:0] op_l, op_l_nx;
  logic fast_nx, neg_nx, done_nx;
  logic pre, d_mul, d_div, d_divd, d_rem, d_fast, unused;
  assign unused = alpctl_h[5];
  assign pre = alpctl_h[9:6] == 4'b1001 && alpctl_h[3] && alu_0xxx_l;
  assign d_mul = pre && alpctl_h[1:0] == 2'b01;
  assign d_div = pre && alpctl_h[2:0] == 3'b110;
  assign d_divd = pre && alpctl_h[2:0] == 3'b111;
  assign d_rem = pre && alpctl_h[2:0] == 3'b010 && !alpctl_h[4];
  assign d_fast = !alpctl_h[1] && (d_mul || d_div);
  assign {mul_l, div_l, divdbl_l, rem_l} = op_l;
  assign busy_h = state != IDLE;
  assign loop_flag_h = state == LOOP && count != '0;
  assign last_step_h = state == LOOP && count == '0;
  assign fix_h = state == FIX;
  assign shl_op_h = state == LOOP && (!div_l || !divdbl_l);
  assign shr_op_h = state == LOOP && !mul_l;
  assign count_h = count;
  always_comb begin
    state_nx = state;
    count_nx = count;
    op_l_nx = op_l;
    fast_nx = fast_h;
    neg_nx = neg_h;
    done_nx = 1'b0;
    if (stall_h) begin
      state_nx = state;
    end else if (abort_h) begin
      state_nx = IDLE;
      count_nx = '0;
    end else begin
      case (state)
        IDLE: if (d_mul || d_div || d_divd || d_rem) begin
          op_l_nx = ~{d_mul, d_div, d_divd, d_rem};
          fast_nx = d_fast;
          neg_nx = alpctl_h[4];
          state_nx = d_rem ? FIX : LOOP;
          count_nx = d_rem ? count : (d_fast ? CNT_FAST : CNT_SLOW);
        end
        LOOP: if (count == '0) begin
          state_nx = !mul_l ? IDLE : FIX;
          done_nx = !mul_l;
        end else begin
          count_nx = count - 1'b1;
        end
        FIX: begin
          state_nx = IDLE;
          done_nx = 1'b1;
        end
        default: state_nx = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk_h) begin
    if (!reset_l) begin
      state <= IDLE;
      count <= '0;
      op_l <= '1;
      fast_h <= 1'b0;
      neg_h <= 1'b0;
      done_h <= 1'b0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      op_l <= op_l_nx;
      fast_h <= fast_nx;
      neg_h <= neg_nx;
      done_h <= done_nx;
    end
  end
endmodule

// File: tb/tb_alk_mdseq.sv
// tb_alk_mdseq: directed and random checks of alk_mdseq against a per-op expected-trace model
module tb_alk_mdseq;
  typedef struct packed {
    logic busy, lf, ls, fix, shl, shr, done;
    logic [5:0] cnt;
  } rec_t;
  logic clk_h = 0, reset_l = 0, alu_0xxx_l = 1, stall_h = 0, abort_h = 0;
  logic [9:0] alpctl_h = '0;
  logic busy_h, loop_flag_h, last_step_h, fix_h, shl_op_h, shr_op_h, fast_h, neg_h;
  logic mul_l, div_l, divdbl_l, rem_l, done_h;
  logic [5:0] count_h;
  int passed = 0, total = 0;
  rec_t q[$];
  rec_t cur = '0;
  logic [3:0] m_opl = 4'hF;
  logic m_fast = 0, m_neg = 0;
  logic [9:0] codes [6] = '{10'h269, 10'h26D, 10'h26E, 10'h26F, 10'h26A, 10'h268};
  alk_mdseq dut (
    .clk_h(clk_h), .reset_l(reset_l), .alpctl_h(alpctl_h), .alu_0xxx_l(alu_0xxx_l),
    .stall_h(stall_h), .abort_h(abort_h), .busy_h(busy_h), .loop_flag_h(loop_flag_h),
    .last_step_h(last_step_h), .fix_h(fix_h), .shl_op_h(shl_op_h), .shr_op_h(shr_op_h),
    .fast_h(fast_h), .neg_h(neg_h), .mul_l(mul_l), .div_l(div_l), .divdbl_l(divdbl_l),
    .rem_l(rem_l), .done_h(done_h), .count_h(count_h)
  );
  always #5 clk_h = ~clk_h;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  function automatic int kind_of(input logic [9:0] c, input logic alu);
    if (c[9:6] != 4'd9 || !c[3] || !alu) return -1;
    if (c[1:0] == 2'b01) return 0;
    if (c[2:0] == 3'b110) return 1;
    if (c[2:0] == 3'b111) return 2;
    if (c[2:0] == 3'b010 && !c[4]) return 3;
    return -1;
  endfunction
  task automatic launch(input int k, input logic [9:0] c);
    int n;
    rec_t r;
    m_fast = (k <= 1) && !c[1];
    m_neg = c[4];
    m_opl = ~(4'b1000 >> k);
    n = m_fast ? 16 : 32;
    if (k != 3)
      for (int i = n - 1; i >= 0; i--) begin
        r = '0;
        r.busy = 1; r.lf = i != 0; r.ls = i == 0; r.shl = k == 1 || k == 2; r.shr = k == 0;
        r.cnt = 6'(i);
        q.push_back(r);
      end
    if (k != 0) begin
      r = '0; r.busy = 1; r.fix = 1;
      q.push_back(r);
    end
    r = '0; r.done = 1;
    q.push_back(r);
  endtask
  task automatic step(input logic rl, input logic st, input logic ab, input logic [9:0] c, input logic alu);
    int k;
    reset_l = rl; stall_h = st; abort_h = ab; alpctl_h = c; alu_0xxx_l = alu;
    @(posedge clk_h);
    k = kind_of(c, alu);
    if (!rl) begin
      q.delete(); cur = '0; m_opl = 4'hF; m_fast = 0; m_neg = 0;
    end else if (st) cur.done = 0;
    else if (ab) begin
      q.delete(); cur = '0;
    end else if (q.size() != 0) cur = q.pop_front();
    else if (k >= 0) begin
      launch(k, c); cur = q.pop_front();
    end else cur = '0;
    #1;
    chk("busy", busy_h, cur.busy);
    chk("loop_flag", loop_flag_h, cur.lf);
    chk("last_step", last_step_h, cur.ls);
    chk("fix", fix_h, cur.fix);
    chk("shl", shl_op_h, cur.shl);
    chk("shr", shr_op_h, cur.shr);
    chk("done", done_h, cur.done);
    chk("count", count_h, cur.cnt);
    if (cur.busy || !rl) begin
      chk("op_l", {mul_l, div_l, divdbl_l, rem_l}, m_opl);
      chk("fast", fast_h, m_fast);
      chk("neg", neg_h, m_neg);
    end
  endtask
  task automatic run_to_done(input int lim);
    int k = 0;
    while (!cur.done && k < lim) begin
      step(1, 0, 0, 10'h0, 1);
      k++;
    end
    chk("done_timeout", 32'(k < lim), 1);
  endtask
  task automatic run_to_cnt(input logic [5:0] c, input int lim);
    int k = 0;
    while (cur.cnt != c && k < lim) begin
      step(1, 0, 0, 10'h0, 1);
      k++;
    end
    chk("cnt_timeout", 32'(k < lim), 1);
  endtask
  initial begin
    step(0, 0, 0, 10'h269, 1);
    step(0, 0, 1, 10'h26E, 1);
    step(1, 0, 0, 10'h0, 1);
    step(1, 0, 0, 10'h269, 1);
    chk("mul_load", count_h, 15);
    run_to_done(40);
    step(1, 0, 0, 10'h26E, 1);
    chk("div_load", count_h, 31);
    run_to_done(40);
    step(1, 0, 0, 10'h26A, 1);
    chk("rem_fix", fix_h, 1);
    run_to_done(5);
    step(1, 0, 0, 10'h26E, 1);
    run_to_cnt(5, 40);
    repeat (3) step(1, 1, 0, 10'h0, 1);
    chk("stall_hold", count_h, 5);
    run_to_done(40);
    step(1, 0, 0, 10'h269, 1);
    run_to_cnt(10, 20);
    step(1, 0, 1, 10'h0, 1);
    step(1, 0, 0, 10'h26F, 1);
    repeat (4) step(1, 0, 0, 10'h0, 1);
    step(0, 0, 0, 10'h0, 1);
    step(1, 0, 0, 10'h0, 1);
    step(1, 0, 0, 10'h269, 1);
    run_to_done(40);
    step(1, 0, 0, 10'h26E, 1);
    chk("b2b_start", busy_h, 1);
    run_to_done(40);
    step(1, 1, 0, 10'h269, 1);
    step(1, 0, 1, 10'h269, 1);
    step(1, 0, 0, 10'h26A, 0);
    step(1, 0, 0, 10'h36C, 1);
    step(1, 0, 0, 10'h27A, 1);
    for (int i = 0; i < 600; i++) begin
      logic [9:0] c;
      c = $urandom_range(0, 3) == 0 ? 10'($urandom) : codes[$urandom_range(0, 5)];
      step($urandom_range(0, 199) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 31) == 0,
           c, $urandom_range(0, 7) != 0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
